// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the renderers and the DAC.
// master drives the raster; slave is any consumer of counters and sync.
interface vga_timing_gen_if;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       hsync;
  logic       vsync;
  logic       video_active;
  logic       pix_tick;
  logic       vga_clk;
  logic       frame_start;

  modport master (
    output h_counter, v_counter, hsync, vsync, video_active,
    output pix_tick, vga_clk, frame_start
  );

  modport slave (
    input h_counter, v_counter, hsync, vsync, video_active,
    input pix_tick, vga_clk, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides clk down to the pixel rate and produces counters,
// active-low syncs, blanking, a DAC pixel clock and a per-frame strobe.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic             DIV_BYPASS = (CLK_DIV == 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             div_wrap;
  logic             tick;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       v_wrap;

  logic       hsync_q;
  logic       vsync_q;
  logic       active_q;
  logic       vga_clk_q;
  logic       frame_start_q;

  logic       hsync_zone;
  logic       vsync_zone;
  logic       active_next;

  // Pixel-rate divider.
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    div_next = div_wrap ? '0 : div_cnt + 1'b1;
  end

  // Gating with reset keeps pix_tick low while reset is held, yet lets a
  // CLK_DIV=1 build tick on the very first cycle after release.
  assign tick = reset & div_wrap;

  // Next raster position, used both for the counters and for the decode.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Decoding the next position lets the registered syncs line up with the counters.
  always_comb begin
    hsync_zone  = ({1'b0, h_next} >= H_SYNC_BEG) && ({1'b0, h_next} < H_SYNC_END);
    vsync_zone  = ({1'b0, v_next} >= V_SYNC_BEG) && ({1'b0, v_next} < V_SYNC_END);
    active_next = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt       <= '0;
      h_cnt         <= 10'd0;
      v_cnt         <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt       <= div_next;
      vga_clk_q     <= DIV_BYPASS ? 1'b1 : (div_next >= DIV_HALF);
      frame_start_q <= tick && h_wrap && v_wrap;
      if (tick) begin
        h_cnt    <= h_next;
        v_cnt    <= v_next;
        hsync_q  <= ~hsync_zone;
        vsync_q  <= ~vsync_zone;
        active_q <= active_next;
      end
    end
  end

  assign vga.h_counter    = h_cnt;
  assign vga.v_counter    = v_cnt;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.video_active = active_q;
  assign vga.pix_tick     = tick;
  assign vga.vga_clk      = vga_clk_q;
  assign vga.frame_start  = frame_start_q;

endmodule
